// File: rtl/axi_sram_slave.sv
// AXI4-Lite SRAM responder: word-addressed single-port array behind
// independent read and write channel FSMs, one transaction in flight per
// direction, fixed read latency and SLVERR outside the mapped window.
module axi_sram_slave #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 64,
   parameter int unsigned       DEPTH_LOG2 = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned       RD_LAT     = 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [ADDR_W-1:0]   s_awaddr,
   input  logic                s_wvalid,
   output logic                s_wready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_bvalid,
   input  logic                s_bready,
   output logic [1:0]          s_bresp,
   input  logic                s_arvalid,
   output logic                s_arready,
   input  logic [ADDR_W-1:0]   s_araddr,
   output logic                s_rvalid,
   input  logic                s_rready,
   output logic [DATA_W-1:0]   s_rdata,
   output logic [1:0]          s_rresp
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
   localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + ((ADDR_W+1)'(DEPTH) << OFF_W);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return DEPTH_LOG2'((a - BASE_ADDR) >> OFF_W);
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   logic rdy_en_q;

   w_state_t          w_state_q;
   logic [ADDR_W-1:0] awaddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic [1:0]        bresp_q;

   r_state_t          r_state_q;
   logic [ADDR_W-1:0] araddr_q;
   logic [3:0]        cnt_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;

   logic              aw_hs, w_hs, ar_hs;
   logic              wr_commit, wr_ok;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [STRB_W-1:0] wr_strb;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ok;
   logic [DATA_W-1:0] rd_word;

   assign s_awready = rdy_en_q & ((w_state_q == W_IDLE) | (w_state_q == W_HAVE_D));
   assign s_wready  = rdy_en_q & ((w_state_q == W_IDLE) | (w_state_q == W_HAVE_A));
   assign s_bvalid  = (w_state_q == W_RESP);
   assign s_bresp   = bresp_q;
   assign s_arready = rdy_en_q & (r_state_q == R_IDLE);
   assign s_rvalid  = (r_state_q == R_DATA);
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;

   assign aw_hs = s_awvalid & s_awready;
   assign w_hs  = s_wvalid & s_wready;
   assign ar_hs = s_arvalid & s_arready;

   // Ready outputs stay low for one cycle after reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rdy_en_q <= 1'b0;
      else          rdy_en_q <= 1'b1;
   end

   // Select the write payload: latched half plus whichever half fires now.
   always_comb begin
      wr_commit = 1'b0;
      wr_addr   = awaddr_q;
      wr_data   = wdata_q;
      wr_strb   = wstrb_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_commit = 1'b1;
               wr_addr   = s_awaddr;
               wr_data   = s_wdata;
               wr_strb   = s_wstrb;
            end
         end
         W_HAVE_A: begin
            if (w_hs) begin
               wr_commit = 1'b1;
               wr_data   = s_wdata;
               wr_strb   = s_wstrb;
            end
         end
         W_HAVE_D: begin
            if (aw_hs) begin
               wr_commit = 1'b1;
               wr_addr   = s_awaddr;
            end
         end
         default: ;
      endcase
   end

   assign wr_ok = in_range(wr_addr);

   // Write channel FSM; response code is captured on the commit edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         w_state_q <= W_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= '0;
      end else begin
         unique case (w_state_q)
            W_IDLE: begin
               if (aw_hs && w_hs) begin
                  w_state_q <= W_RESP;
               end else if (aw_hs) begin
                  awaddr_q  <= s_awaddr;
                  w_state_q <= W_HAVE_A;
               end else if (w_hs) begin
                  wdata_q   <= s_wdata;
                  wstrb_q   <= s_wstrb;
                  w_state_q <= W_HAVE_D;
               end
            end
            W_HAVE_A: if (w_hs)     w_state_q <= W_RESP;
            W_HAVE_D: if (aw_hs)    w_state_q <= W_RESP;
            W_RESP:   if (s_bready) w_state_q <= W_IDLE;
            default:                w_state_q <= W_IDLE;
         endcase
         if (wr_commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Byte-lane array update; not reset so contents survive i_rst_n.
   always_ff @(posedge i_clk) begin
      if (wr_commit && wr_ok) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // With RD_LAT == 1 the sample happens on the AR edge, so use the live address.
   assign rd_addr = (r_state_q == R_IDLE) ? s_araddr : araddr_q;
   assign rd_ok   = in_range(rd_addr);
   assign rd_word = mem[word_idx(rd_addr)];

   // Read channel FSM; array sampled on the edge entering R_DATA.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state_q <= R_IDLE;
         araddr_q  <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         unique case (r_state_q)
            R_IDLE: begin
               if (ar_hs) begin
                  araddr_q <= s_araddr;
                  cnt_q    <= 4'(RD_LAT - 1);
                  if (RD_LAT <= 1) begin
                     r_state_q <= R_DATA;
                     rdata_q   <= rd_ok ? rd_word : '0;
                     rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                  end else begin
                     r_state_q <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  r_state_q <= R_DATA;
                  rdata_q   <= rd_ok ? rd_word : '0;
                  rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
               end
            end
            R_DATA:  if (s_rready) r_state_q <= R_IDLE;
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: an RD_LAT=1 and an RD_LAT=4 instance
// share the write channel; each has its own AR/R handshake lines.
module tb_axi_sram_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, wvalid, bready, arv, rr, sel4;
   logic [31:0] awaddr, araddr;
   logic [63:0] wdata;
   logic [7:0]  wstrb;

   logic        awready1, wready1, bvalid1, arready1, rvalid1;
   logic [1:0]  bresp1, rresp1;
   logic [63:0] rdata1;
   logic        awready4, wready4, bvalid4, arready4, rvalid4;
   logic [1:0]  bresp4, rresp4;
   logic [63:0] rdata4;

   logic        arvalid1, arvalid4, rready1, rready4;
   logic        arr, rv;
   logic [63:0] rd;
   logic [1:0]  rs;

   int n_chk = 0;
   int n_err = 0;

   logic [63:0] d;
   logic [1:0]  r;
   int          lat;

   always #5 clk = ~clk;

   assign arvalid1 = arv & ~sel4;
   assign arvalid4 = arv & sel4;
   assign rready1  = rr & ~sel4;
   assign rready4  = rr & sel4;
   assign arr = sel4 ? arready4 : arready1;
   assign rv  = sel4 ? rvalid4  : rvalid1;
   assign rd  = sel4 ? rdata4   : rdata1;
   assign rs  = sel4 ? rresp4   : rresp1;

   axi_sram_slave #(.RD_LAT(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .s_awvalid(awvalid), .s_awready(awready1), .s_awaddr(awaddr),
      .s_wvalid(wvalid), .s_wready(wready1), .s_wdata(wdata), .s_wstrb(wstrb),
      .s_bvalid(bvalid1), .s_bready(bready), .s_bresp(bresp1),
      .s_arvalid(arvalid1), .s_arready(arready1), .s_araddr(araddr),
      .s_rvalid(rvalid1), .s_rready(rready1), .s_rdata(rdata1), .s_rresp(rresp1)
   );

   axi_sram_slave #(.RD_LAT(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n),
      .s_awvalid(awvalid), .s_awready(awready4), .s_awaddr(awaddr),
      .s_wvalid(wvalid), .s_wready(wready4), .s_wdata(wdata), .s_wstrb(wstrb),
      .s_bvalid(bvalid4), .s_bready(bready), .s_bresp(bresp4),
      .s_arvalid(arvalid4), .s_arready(arready4), .s_araddr(araddr),
      .s_rvalid(rvalid4), .s_rready(rready4), .s_rdata(rdata4), .s_rresp(rresp4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] s,
                     output logic [1:0] resp);
      int n;
      awaddr = a; wdata = dat; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid1 && n < 20) begin @(negedge clk); n++; end
      if (!bvalid1) chk("wr_timeout", {63'b0, bvalid1}, 64'd1);
      resp = bresp1;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic rdt(input logic [31:0] a, output logic [63:0] dat, output logic [1:0] resp,
                      output int l);
      araddr = a; arv = 1'b1;
      @(negedge clk);
      arv = 1'b0;
      l = 1;
      while (!rv && l < 20) begin @(negedge clk); l++; end
      if (!rv) chk("rd_timeout", {63'b0, rv}, 64'd1);
      dat = rd; resp = rs;
      rr = 1'b1;
      @(negedge clk);
      rr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      awvalid = 0; wvalid = 0; bready = 0; arv = 0; rr = 0; sel4 = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_awready", awready1, 0);
      chk("rst_wready",  wready1,  0);
      chk("rst_arready", arready1, 0);
      chk("rst_bvalid",  bvalid1,  0);
      chk("rst_rvalid",  rvalid1,  0);
      chk("rst_bresp",   bresp1,   0);
      chk("rst_rresp",   rresp1,   0);
      chk("rst_rdata",   rdata1,   0);
      chk("rst_arready4", arready4, 0);
      rst_n = 1'b1;
      #1 chk("rdy_gate", awready1, 0);
      @(negedge clk);
      chk("rdy_aw", awready1, 1);
      chk("rdy_w",  wready1,  1);
      chk("rdy_ar", arready1, 1);

      // 1: same-cycle AW+W, then read back
      awaddr = 32'h8000_0008; wdata = 64'h1122_3344_5566_7788; wstrb = 8'hFF;
      awvalid = 1; wvalid = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk("t1_bvalid",  bvalid1,  1);
      chk("t1_bresp",   bresp1,   0);
      chk("t1_awready", awready1, 0);
      chk("t1_wready",  wready1,  0);
      bready = 1;
      @(negedge clk);
      bready = 0;
      chk("t1_bdone",   bvalid1,  0);
      chk("t1_idle_aw", awready1, 1);
      rdt(32'h8000_0008, d, r, lat);
      chk("t1_lat", lat, 1);
      chk("t1_rdata", d, 64'h1122_3344_5566_7788);
      chk("t1_rresp", r, 0);

      // 2: W first, AW three cycles later
      wdata = 64'hAAAA_AAAA_BBBB_BBBB; wstrb = 8'h0F; wvalid = 1;
      @(negedge clk);
      wvalid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_hd_aw", awready1, 1);
         chk("t2_hd_w",  wready1,  0);
         chk("t2_hd_b",  bvalid1,  0);
         if (i < 2) @(negedge clk);
      end
      awaddr = 32'h8000_0008; awvalid = 1;
      @(negedge clk);
      awvalid = 0;
      chk("t2_bvalid", bvalid1, 1);
      chk("t2_bresp",  bresp1,  0);
      bready = 1;
      @(negedge clk);
      bready = 0;
      rdt(32'h8000_0008, d, r, lat);
      chk("t2_rdata", d, 64'h1122_3344_BBBB_BBBB);
      rdt(32'h8000_000C, d, r, lat);
      chk("t2_unaligned", d, 64'h1122_3344_BBBB_BBBB);

      // AW first, W one cycle later
      awaddr = 32'h8000_0000; awvalid = 1;
      @(negedge clk);
      awvalid = 0;
      chk("ha_aw", awready1, 0);
      chk("ha_w",  wready1,  1);
      wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF; wvalid = 1;
      @(negedge clk);
      wvalid = 0;
      chk("ha_bvalid", bvalid1, 1);
      bready = 1;
      @(negedge clk);
      bready = 0;

      // 4: out of range
      wr(32'h8000_7FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, r);
      chk("t4_top_bresp", r, 0);
      wr(32'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
      chk("t4_low_bresp", r, 2);
      rdt(32'h8000_7FF8, d, r, lat);
      chk("t4_top_keep", d, 64'hDEAD_BEEF_CAFE_F00D);
      chk("t4_top_rresp", r, 0);
      rdt(32'h8000_0000, d, r, lat);
      chk("t4_w0_keep", d, 64'h0123_4567_89AB_CDEF);
      rdt(32'h8000_8000, d, r, lat);
      chk("t4_oor_rdata", d, 0);
      chk("t4_oor_rresp", r, 2);

      // 5: read sample and write commit on the same edge
      wr(32'h8000_0010, 64'h0, 8'hFF, r);
      awaddr = 32'h8000_0010; awvalid = 1;
      @(negedge clk);
      awvalid = 0;
      wdata = 64'h55; wstrb = 8'hFF; wvalid = 1;
      araddr = 32'h8000_0010; arv = 1;
      @(negedge clk);
      wvalid = 0; arv = 0;
      chk("t5_rvalid", rvalid1, 1);
      chk("t5_old",    rdata1,  0);
      chk("t5_bvalid", bvalid1, 1);
      rr = 1; bready = 1;
      @(negedge clk);
      rr = 0; bready = 0;
      rdt(32'h8000_0010, d, r, lat);
      chk("t5_new", d, 64'h55);

      // 3: RD_LAT=4 latency and backpressure
      sel4 = 1;
      araddr = 32'h8000_0008; arv = 1;
      chk("t3_arready", arr, 1);
      @(negedge clk);
      arv = 0;
      for (int i = 1; i < 4; i++) begin
         chk("t3_wait", rv, 0);
         @(negedge clk);
      end
      chk("t3_rvalid", rv, 1);
      chk("t3_rdata", rd, 64'h1122_3344_BBBB_BBBB);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_v", rv, 1);
         chk("t3_hold_d", rd, 64'h1122_3344_BBBB_BBBB);
      end
      rr = 1;
      @(negedge clk);
      rr = 0;
      chk("t3_done", rv, 0);
      chk("t3_idle", arr, 1);

      // 6: reset while dut4 in R_WAIT and writes in W_HAVE_A
      araddr = 32'h8000_0008; arv = 1;
      awaddr = 32'h8000_0018; awvalid = 1;
      @(negedge clk);
      arv = 0; awvalid = 0;
      chk("t6_rwait_rv", rvalid4, 0);
      chk("t6_rwait_ar", arready4, 0);
      chk("t6_ha_w", wready1, 1);
      #2 rst_n = 0;
      #1;
      chk("t6_rst_w",   wready1,  0);
      chk("t6_rst_ar4", arready4, 0);
      chk("t6_rst_rv4", rvalid4,  0);
      chk("t6_rst_b",   bvalid1,  0);
      @(negedge clk);
      rst_n = 1;
      #1 chk("t6_gate_w", wready1, 0);
      @(negedge clk);
      chk("t6_idle_aw",  awready1, 1);
      chk("t6_idle_w",   wready1,  1);
      chk("t6_idle_ar4", arready4, 1);
      chk("t6_idle_rv4", rvalid4,  0);
      sel4 = 0;

      // Reset while responses are pending must drop them immediately
      araddr = 32'h8000_0008; arv = 1;
      awaddr = 32'h8000_0020; wdata = 64'h7777_0000_7777_0000; wstrb = 8'hFF;
      awvalid = 1; wvalid = 1;
      @(negedge clk);
      arv = 0; awvalid = 0; wvalid = 0;
      chk("rp_rvalid", rvalid1, 1);
      chk("rp_bvalid", bvalid1, 1);
      rst_n = 0;
      #1;
      chk("rp_rst_rv", rvalid1, 0);
      chk("rp_rst_bv", bvalid1, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      rdt(32'h8000_0008, d, r, lat);
      chk("mem_keep", d, 64'h1122_3344_BBBB_BBBB);
      rdt(32'h8000_0020, d, r, lat);
      chk("mem_keep2", d, 64'h7777_0000_7777_0000);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4-Lite responder (slave) backing the core's instruction-fetch and load/store initiators with a single-ported, word-addressed SRAM model.
- Sits outside the pipeline, across the AXI boundary from the fetch and LSU bus masters.
- Independent read and write channel FSMs, one outstanding transaction per direction.
- Programmable read latency and SLVERR for out-of-range addresses.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, data width; byte lanes = DATA_W/8.
- DEPTH_LOG2, 12, log2 of word count; words are DATA_W wide.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR handshake to RVALID; legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_awaddr  in  ADDR_W  write byte address
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_wdata  in  DATA_W  write data
- s_wstrb  in  DATA_W/8  byte enables
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_bresp  out  2  00 OKAY, 10 SLVERR
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_araddr  in  ADDR_W  read byte address
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_rdata  out  DATA_W  read data
- s_rresp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset, async assert: all outputs 0. Memory contents are not cleared and are undefined.
- A registered rdy_en flop goes to 1 on the first clock edge after reset deasserts. All ready outputs are gated by rdy_en.
- Word index = (addr - BASE_ADDR) >> log2(DATA_W/8). Low byte-offset bits are ignored; unaligned addresses are treated as aligned.
- An address is in range when BASE_ADDR <= addr < BASE_ADDR + (2^DEPTH_LOG2)*(DATA_W/8). Anything else gets SLVERR.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - W_IDLE: awready = wready = 1.
  - AW and W fire in the same cycle: go to W_RESP.
  - AW only: latch address, go to W_HAVE_A, where only wready = 1.
  - W only: latch data and strobe, go to W_HAVE_D, where only awready = 1.
  - The missing half fires: go to W_RESP.
- Memory commits on the edge entering W_RESP. Only lanes with wstrb set are written. Out-of-range writes are dropped.
- W_RESP: bvalid = 1, bresp held stable. When bvalid & bready, return to W_IDLE. No new AW/W is accepted until then.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready = 1. On AR handshake, latch address and load the counter with RD_LAT-1.
  - RD_LAT = 1: go directly to R_DATA. Otherwise go to R_WAIT and decrement each cycle; at 0, go to R_DATA.
  - Data is sampled from the array on the edge entering R_DATA.
  - R_DATA: rvalid = 1. rdata and rresp stay stable until rvalid & rready, then return to R_IDLE. Back-to-back ARs are therefore separated by at least one idle cycle.
- Out-of-range read: rdata = 0, rresp = 10.
- Same-edge collision, where the write commit and the read sample hit the same word: the read returns the old data.
- Reset asserted mid-transaction: both FSMs return to idle immediately, pending responses are dropped, and memory keeps its contents.
- Backpressure: rvalid and bvalid are never deasserted without a handshake, and their payloads never change while valid.

Test Plan:
1. Reset then write: deassert reset, wait 1 cycle; write AW=0x8000_0008, W=0x1122_3344_5566_7788, wstrb=0xFF in the same cycle → bvalid in the next cycle, bresp=00. Read 0x8000_0008 with RD_LAT=1 → rvalid 1 cycle after AR, rdata=0x1122_3344_5566_7788, rresp=00.
2. Split write ordering: W first (wstrb=0x0F, data 0xAAAA_AAAA_BBBB_BBBB), AW 3 cycles later at 0x8000_0008 → state W_HAVE_D until AW arrives, then bvalid. A read of the same address returns 0x1122_3344_BBBB_BBBB.
3. Read latency: RD_LAT=4 build, AR at cycle t → rvalid first high at cycle t+4. Hold rready=0 for 5 cycles → rvalid and rdata stay stable; the handshake completes on the first cycle rready=1.
4. Out of range: write to 0x7FFF_FFF8 → bresp=10 and memory unchanged. Read from BASE_ADDR + 2^DEPTH_LOG2*8 → rresp=10, rdata=0.
5. Collision: AR and the final write handshake to the same word land on the same edge (old value 0x0, new 0x55) → read returns 0x0; the next read returns 0x55.
6. Mid-transaction reset: assert i_rst_n=0 while in R_WAIT and W_HAVE_A → rvalid=bvalid=0 immediately. After release, the ready outputs stay 0 for 1 cycle, then arready=awready=wready=1.
